// File: rtl/eth_tx_arbiter_pkg.sv
// eth_tx_arbiter_pkg: shared types for the ETH1 TX arbiter slice.
// Holds the arbiter state encoding, the beat bundle and a saturating helper.
package eth_tx_arbiter_pkg;

    localparam int LP_DATA_W = 64;
    localparam int LP_KEEP_W = LP_DATA_W / 32;

    typedef enum logic [2:0] {
        IDLE,
        GRANT0,
        GRANT1,
        DROP0,
        DROP1
    } arb_state_t;

    typedef struct packed {
        logic [LP_DATA_W-1:0] tdata;
        logic [LP_KEEP_W-1:0] tkeep;
        logic                 tlast;
        logic                 tuser;
    } axis_beat_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: AXI-Stream bundle (tdata/tkeep/tlast/tuser/tvalid/tready).
// master drives payload+tvalid, slave drives tready.
interface eth_tx_arbiter_if
    import eth_tx_arbiter_pkg::*;
#(
    parameter int DW = LP_DATA_W,
    parameter int KW = DW / 32
) ();
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic          tuser;
    logic          tvalid;
    logic          tready;

    modport master (
        output tdata, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/eth_tx_arbiter_skid.sv
// axis_skid_slice: 2-entry registered skid buffer for one axis_beat_t stream.
// Ports: i_clk/i_rst, input beat+valid/ready, output beat+valid/ready.
module axis_skid_slice
    import eth_tx_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  axis_beat_t i_beat,
    input  logic       i_valid,
    output logic       o_ready,
    output axis_beat_t o_beat,
    output logic       o_valid,
    input  logic       i_ready
);
    axis_beat_t r_main;
    axis_beat_t r_skid;
    logic       r_main_vld;
    logic       r_skid_vld;
    logic       w_in_fire;

    // Ready depends only on local state, so upstream never sees
    // a combinational path from downstream tready.
    assign o_ready   = ~r_skid_vld;
    assign w_in_fire = i_valid & ~r_skid_vld;
    assign o_beat    = r_main;
    assign o_valid   = r_main_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_main_vld || i_ready) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_main_vld <= w_in_fire;
                if (w_in_fire) r_main <= i_beat;
            end
        end else if (w_in_fire) begin
            // Output stalled: park the beat so the main register holds.
            r_skid     <= i_beat;
            r_skid_vld <= 1'b1;
        end
    end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-granular 2:1 round-robin AXIS arbiter, truncating
// oversize frames. Ports: clk156, sys_rst, s0/s1 slave, m master, stats.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int C_DATA_WIDTH = LP_DATA_W,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
    parameter int MAX_BEATS    = 256
) (
    input  logic                   clk156,
    input  logic                   sys_rst,
    eth_tx_arbiter_if.slave        s0_axis,
    eth_tx_arbiter_if.slave        s1_axis,
    eth_tx_arbiter_if.master       m_axis,
    output logic [31:0]            frames_fwd0,
    output logic [31:0]            frames_fwd1,
    output logic [15:0]            trunc_cnt
);
    localparam int LP_BW = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [LP_BW-1:0] LP_LAST = LP_BW'(MAX_BEATS - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_last_grant;
    logic [LP_BW-1:0]  r_beat_cnt;
    logic [31:0]       r_fwd0;
    logic [31:0]       r_fwd1;
    logic [15:0]       r_trunc_cnt;

    logic                    w_sel1;
    logic                    w_src_vld;
    logic                    w_src_last;
    logic                    w_oth_vld;
    logic [C_DATA_WIDTH-1:0] w_src_data;
    logic [KEEP_WIDTH-1:0]   w_src_keep;
    logic                    w_rdy;
    logic                    w_fwd;
    logic                    w_fire;
    logic                    w_trunc;
    logic                    w_can;
    axis_beat_t              w_in_beat;
    axis_beat_t              w_out_beat;
    logic                    w_out_vld;

    assign w_sel1     = (r_state == GRANT1) || (r_state == DROP1);
    assign w_src_vld  = w_sel1 ? s1_axis.tvalid : s0_axis.tvalid;
    assign w_src_last = w_sel1 ? s1_axis.tlast  : s0_axis.tlast;
    assign w_src_data = w_sel1 ? s1_axis.tdata  : s0_axis.tdata;
    assign w_src_keep = w_sel1 ? s1_axis.tkeep  : s0_axis.tkeep;
    assign w_oth_vld  = w_sel1 ? s0_axis.tvalid : s1_axis.tvalid;

    assign w_fire  = w_src_vld & w_rdy;
    // Last allowed beat without tlast: forward it as a forced end.
    assign w_trunc = w_fwd & (r_beat_cnt == LP_LAST) & ~w_src_last;

    assign s0_axis.tready = w_rdy & ~w_sel1;
    assign s1_axis.tready = w_rdy & w_sel1;

    always_ff @(posedge clk156) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (s0_axis.tvalid && s1_axis.tvalid)
                    w_next = r_last_grant ? GRANT0 : GRANT1;
                else if (s0_axis.tvalid)
                    w_next = GRANT0;
                else if (s1_axis.tvalid)
                    w_next = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (w_fire) begin
                    if (w_trunc)
                        w_next = w_sel1 ? DROP1 : DROP0;
                    else if (w_src_last && w_oth_vld)
                        w_next = w_sel1 ? GRANT0 : GRANT1;
                end else if (r_beat_cnt == '0 && !w_src_vld) begin
                    // Between frames with nothing offered: release.
                    w_next = IDLE;
                end
            end
            DROP0, DROP1: begin
                if (w_fire && w_src_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rdy = 1'b0;
        w_fwd = 1'b0;
        unique case (r_state)
            GRANT0, GRANT1: begin
                w_rdy = w_can;
                w_fwd = 1'b1;
            end
            DROP0, DROP1: w_rdy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_in_beat       = '0;
        w_in_beat.tdata = w_src_data;
        w_in_beat.tkeep = w_src_keep;
        w_in_beat.tlast = w_src_last | w_trunc;
        w_in_beat.tuser = w_trunc;
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            r_last_grant <= 1'b1;
            r_beat_cnt   <= '0;
            r_fwd0       <= '0;
            r_fwd1       <= '0;
            r_trunc_cnt  <= '0;
        end else if (w_fire && w_fwd) begin
            if (w_src_last || w_trunc) r_beat_cnt <= '0;
            else                       r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_trunc) begin
                r_trunc_cnt <= sat_inc16(r_trunc_cnt);
            end else if (w_src_last) begin
                r_last_grant <= w_sel1;
                if (w_sel1) r_fwd1 <= r_fwd1 + 32'd1;
                else        r_fwd0 <= r_fwd0 + 32'd1;
            end
        end else if (w_fire && w_src_last) begin
            r_last_grant <= w_sel1;
        end
    end

    axis_skid_slice u_slice (
        .i_clk   (clk156),
        .i_rst   (sys_rst),
        .i_beat  (w_in_beat),
        .i_valid (w_fwd & w_src_vld),
        .o_ready (w_can),
        .o_beat  (w_out_beat),
        .o_valid (w_out_vld),
        .i_ready (m_axis.tready)
    );

    assign m_axis.tdata  = w_out_beat.tdata;
    assign m_axis.tkeep  = w_out_beat.tkeep;
    assign m_axis.tlast  = w_out_beat.tlast;
    assign m_axis.tuser  = w_out_beat.tuser;
    assign m_axis.tvalid = w_out_vld;

    assign frames_fwd0 = r_fwd0;
    assign frames_fwd1 = r_fwd1;
    assign trunc_cnt   = r_trunc_cnt;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed bench for eth_tx_arbiter with a frame-level
// reference model and a per-cycle output checker.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
    import eth_tx_arbiter_pkg::*;

    localparam int MAXB = 4;
    localparam int T2_ORD [4] = '{0, 1, 0, 1};

    typedef struct {
        logic [63:0] d;
        logic [1:0]  k;
        logic        l;
        logic        u;
    } tb_beat_t;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] fwd0;
    logic [31:0] fwd1;
    logic [15:0] trc;

    eth_tx_arbiter_if #(.DW(64), .KW(2)) s0_if ();
    eth_tx_arbiter_if #(.DW(64), .KW(2)) s1_if ();
    eth_tx_arbiter_if #(.DW(64), .KW(2)) m_if ();

    eth_tx_arbiter #(
        .C_DATA_WIDTH (64),
        .KEEP_WIDTH   (2),
        .MAX_BEATS    (MAXB)
    ) dut (
        .clk156      (clk),
        .sys_rst     (sys_rst),
        .s0_axis     (s0_if),
        .s1_axis     (s1_if),
        .m_axis      (m_if),
        .frames_fwd0 (fwd0),
        .frames_fwd1 (fwd1),
        .trunc_cnt   (trc)
    );

    always #3 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    tb_beat_t    sq0[$];
    tb_beat_t    sq1[$];
    tb_beat_t    eq0[$];
    tb_beat_t    eq1[$];
    int          order_q[$];
    logic [31:0] m_fwd0 = '0;
    logic [31:0] m_fwd1 = '0;
    logic [15:0] m_trc = '0;
    int          rdy_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Frame model: a frame longer than MAXB leaves as its first MAXB
    // beats with the last one flagged; only whole frames are counted.
    task automatic send_frame(input int p, input int len, input int id);
        tb_beat_t b;
        tb_beat_t e;
        for (int i = 0; i < len; i++) begin
            b.d = {p[0], id[14:0], i[15:0], $urandom()};
            b.k = (i == len - 1 && id[0]) ? 2'b01 : 2'b11;
            b.l = (i == len - 1);
            b.u = 1'b0;
            e = b;
            if (len > MAXB && i == MAXB - 1) begin
                e.l = 1'b1;
                e.u = 1'b1;
            end
            if (p == 0) sq0.push_back(b);
            else        sq1.push_back(b);
            if (i < MAXB) begin
                if (p == 0) eq0.push_back(e);
                else        eq1.push_back(e);
            end
        end
        if (len > MAXB)
            m_trc = (m_trc == 16'hffff) ? m_trc : m_trc + 16'd1;
        else if (p == 0)
            m_fwd0 = m_fwd0 + 32'd1;
        else
            m_fwd1 = m_fwd1 + 32'd1;
    endtask

    // Sources, sink and upstream reset.
    initial begin
        logic f0;
        logic f1;
        logic rs;
        s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tkeep = '0;
        s0_if.tlast = 1'b0;  s0_if.tuser = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tkeep = '0;
        s1_if.tlast = 1'b0;  s1_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            f0 = s0_if.tvalid & s0_if.tready;
            f1 = s1_if.tvalid & s1_if.tready;
            rs = sys_rst;
            @(posedge clk);
            #1;
            if (rs) begin
                sq0.delete(); sq1.delete();
                eq0.delete(); eq1.delete();
                m_fwd0 = '0; m_fwd1 = '0; m_trc = '0;
            end else begin
                if (f0 && sq0.size() > 0) void'(sq0.pop_front());
                if (f1 && sq1.size() > 0) void'(sq1.pop_front());
            end
            s0_if.tvalid = (sq0.size() > 0);
            if (sq0.size() > 0) begin
                s0_if.tdata = sq0[0].d;
                s0_if.tkeep = sq0[0].k;
                s0_if.tlast = sq0[0].l;
            end
            s1_if.tvalid = (sq1.size() > 0);
            if (sq1.size() > 0) begin
                s1_if.tdata = sq1[0].d;
                s1_if.tkeep = sq1[0].k;
                s1_if.tlast = sq1[0].l;
            end
            m_if.tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
        end
    end

    // Per-cycle output checker.
    initial begin
        tb_beat_t e;
        tb_beat_t pv;
        logic     pstall;
        logic     lock;
        int       lp;
        int       p;
        pstall = 1'b0;
        lock = 1'b0;
        lp = 0;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                pstall = 1'b0;
                lock = 1'b0;
            end else begin
                if (pstall) begin
                    chk("hold_data", m_if.tdata, pv.d);
                    chk("hold_ctl",
                        {m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tuser},
                        {1'b1, pv.k, pv.l, pv.u});
                end
                if (m_if.tvalid && m_if.tready) begin
                    p = int'(m_if.tdata[63]);
                    if (lock) begin
                        chk("no_interleave", p, lp);
                    end else begin
                        order_q.push_back(p);
                        lock = 1'b1;
                        lp = p;
                    end
                    if ((p == 0 && eq0.size() == 0) ||
                        (p == 1 && eq1.size() == 0)) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_beat: got %h, want none",
                                 m_if.tdata);
                    end else begin
                        if (p == 0) e = eq0.pop_front();
                        else        e = eq1.pop_front();
                        chk("beat_data", m_if.tdata, e.d);
                        chk("beat_ctl",
                            {m_if.tkeep, m_if.tlast, m_if.tuser},
                            {e.k, e.l, e.u});
                    end
                    if (m_if.tlast) lock = 1'b0;
                end
                pstall = m_if.tvalid & ~m_if.tready;
                pv.d = m_if.tdata;
                pv.k = m_if.tkeep;
                pv.l = m_if.tlast;
                pv.u = m_if.tuser;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        sys_rst = 1'b1;
        @(posedge clk); #2;
        sys_rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sq0.size() + sq1.size() + eq0.size() + eq1.size()) != 0
               && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (n >= 3000) begin
            n_err++;
            $display("FAIL %s_drain: got %0d beats pending, want 0", nm,
                     sq0.size() + sq1.size() + eq0.size() + eq1.size());
        end
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_fwd0"}, fwd0, m_fwd0);
        chk({nm, "_fwd1"}, fwd1, m_fwd1);
        chk({nm, "_trunc"}, trc, m_trc);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_tvalid"}, m_if.tvalid, 0);
        chk({nm, "_s0_tready"}, s0_if.tready, 0);
        chk({nm, "_s1_tready"}, s1_if.tready, 0);
        chk({nm, "_fwd0_zero"}, fwd0, 0);
        chk({nm, "_fwd1_zero"}, fwd1, 0);
        chk({nm, "_trunc_zero"}, trc, 0);
        chk({nm, "_state"}, 64'(dut.r_state), 64'(IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int run;
        int v;

        do_reset();
        @(negedge clk);
        chk_idle("rst");

        // 1: three back-to-back 4-beat frames from s0
        @(posedge clk); #2;
        for (int f = 0; f < 3; f++) send_frame(0, 4, f + 1);
        n = 0;
        @(negedge clk);
        while (!m_if.tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_if.tvalid) run++;
            @(negedge clk);
        end
        chk("t1_no_gap", run, 12);
        drain("t1");
        chk_cnt("t1");
        chk("t1_fwd0_lit", fwd0, 32'd3);

        // 2: both ports valid together, alternation
        do_reset();
        order_q.delete();
        send_frame(0, 2, 10);
        send_frame(1, 2, 20);
        send_frame(0, 2, 11);
        send_frame(1, 2, 21);
        drain("t2");
        chk("t2_nframes", order_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            v = (i < order_q.size()) ? order_q[i] : -1;
            chk($sformatf("t2_order%0d", i), v, T2_ORD[i]);
        end
        chk_cnt("t2");
        chk("t2_fwd0_lit", fwd0, 32'd2);
        chk("t2_fwd1_lit", fwd1, 32'd2);

        // 3: 7-beat frame on s1 truncated to 4, then normal s0 frame
        do_reset();
        send_frame(1, 7, 30);
        drain("t3a");
        chk("t3_trunc_lit", trc, 16'd1);
        chk("t3_fwd1_lit", fwd1, 32'd0);
        chk_cnt("t3a");
        send_frame(0, 4, 31);
        drain("t3b");
        chk("t3_fwd0_lit", fwd0, 32'd1);
        chk_cnt("t3b");

        // 4: 16 beats from s0 under random backpressure
        do_reset();
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) send_frame(0, 4, 40 + f);
        drain("t4");
        rdy_mode = 0;
        chk_cnt("t4");
        chk("t4_fwd0_lit", fwd0, 32'd4);

        // 5: reset at beat 2 of a 5-beat s0 frame
        do_reset();
        send_frame(0, 5, 50);
        n = 0;
        while (sq0.size() > 3 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("t5_reach_beat2", sq0.size(), 3);
        sys_rst = 1'b1;
        @(posedge clk); #2;
        sys_rst = 1'b0;
        @(negedge clk);
        chk_idle("t5");
        @(posedge clk); #2;
        send_frame(0, 4, 51);
        drain("t5");
        chk("t5_fwd0_lit", fwd0, 32'd1);
        chk_cnt("t5");

        // 6: truncation counter saturation
        do_reset();
        @(posedge clk); #2;
        force dut.r_trunc_cnt = 16'hfffe;
        m_trc = 16'hfffe;
        @(posedge clk); #2;
        release dut.r_trunc_cnt;
        @(negedge clk);
        chk("t6_preload", trc, 16'hfffe);
        @(posedge clk); #2;
        for (int f = 0; f < 3; f++) send_frame(0, 6, 60 + f);
        drain("t6");
        chk("t6_sat_lit", trc, 16'hffff);
        chk_cnt("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
